// File: rtl/yacc_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : yacc_access_ctrl
//  Brief    : YACC compressed-cache front-end sequencer. Round-robin arbiter
//             for two address requesters, tag/LRU lookup, miss fill handshake,
//             LRU touch and one-cycle response. One request in flight.
//             Optional hit/miss counters enabled by macro YACC_PERF_CNT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module yacc_access_ctrl #(
    parameter int ADDR_W = 32,
    parameter int OFF_W  = 6,
    parameter int SB_W   = 2,
    parameter int SET_W  = 3,
    parameter int TAG_W  = 21,
    parameter int WAY_W  = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              req1_ready,
    output logic              lk_valid,
    output logic [TAG_W-1:0]  lk_tag,
    output logic [SET_W-1:0]  lk_set,
    output logic [SB_W-1:0]   lk_sblk,
    input  logic              lk_done,
    input  logic              lk_hit,
    input  logic [WAY_W-1:0]  lk_way,
    output logic              fill_req,
    output logic [ADDR_W-1:0] fill_addr,
    input  logic              fill_ack,
    input  logic [WAY_W-1:0]  fill_way,
    output logic              lru_upd,
    output logic [SET_W-1:0]  lru_set,
    output logic [WAY_W-1:0]  lru_way,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic              rsp_hit,
    output logic [WAY_W-1:0]  rsp_way,
    output logic              busy
`ifdef YACC_PERF_CNT_EN
    ,
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOKUP  = 3'd1,
        LK_WAIT = 3'd2,
        FILL    = 3'd3,
        UPDATE  = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic                rr_q, rr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                id_q, id_d;
    logic                hit_q, hit_d;
    logic [WAY_W-1:0]    way_q, way_d;

    logic                grant0;
    logic                grant1;
    logic                unused_off;

    // Round-robin grant: a lone requester always wins, a tie goes to rr_q.
    assign grant0 = req0_valid && (!req1_valid || !rr_q);
    assign grant1 = req1_valid && (!req0_valid ||  rr_q);

    assign req0_ready = (state_q == IDLE) && grant0;
    assign req1_ready = (state_q == IDLE) && grant1;

    // Address field split; fields stay stable until the next accept.
    assign lk_tag    = addr_q[ADDR_W-1 -: TAG_W];
    assign lk_set    = addr_q[OFF_W+SB_W +: SET_W];
    assign lk_sblk   = addr_q[OFF_W +: SB_W];
    assign fill_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // The byte offset is latched but never needed downstream.
    assign unused_off = ^addr_q[OFF_W-1:0];

    assign lru_set = lk_set;
    assign lru_way = way_q;
    assign rsp_id  = id_q;
    assign rsp_hit = hit_q;
    assign rsp_way = way_q;

    // Strobes decode directly from state so an async reset drops them at once.
    assign lk_valid  = (state_q == LOOKUP);
    assign fill_req  = (state_q == FILL);
    assign lru_upd   = (state_q == UPDATE);
    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);

    // State and transaction-context registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            addr_q  <= '0;
            id_q    <= 1'b0;
            hit_q   <= 1'b0;
            way_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            hit_q   <= hit_d;
            way_q   <= way_d;
        end
    end

    // Next-state logic and context capture for the single in-flight request.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        id_d    = id_q;
        hit_d   = hit_q;
        way_d   = way_q;
        unique case (state_q)
            IDLE: begin
                if (grant0 || grant1) begin
                    addr_d  = grant1 ? req1_addr : req0_addr;
                    id_d    = grant1;
                    rr_d    = ~grant1;
                    state_d = LOOKUP;
                end
            end
            LOOKUP: state_d = LK_WAIT;
            LK_WAIT: begin
                if (lk_done) begin
                    hit_d = lk_hit;
                    if (lk_hit) begin
                        way_d   = lk_way;
                        state_d = UPDATE;
                    end else begin
                        state_d = FILL;
                    end
                end
            end
            FILL: begin
                if (fill_ack) begin
                    way_d   = fill_way;
                    state_d = UPDATE;
                end
            end
            UPDATE: state_d = RESP;
            RESP:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef YACC_PERF_CNT_EN
    logic [15:0] hit_cnt_q;
    logic [15:0] miss_cnt_q;

    // Saturating hit/miss counters, bumped once per completed response.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == RESP) begin
            if (hit_q) begin
                if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end else begin
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_yacc_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_yacc_access_ctrl
//  Brief    : Self-checking bench for yacc_access_ctrl with a response
//             scoreboard queue and directed steps.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_yacc_access_ctrl;

    logic        clock;
    logic        reset_n;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_addr, req1_addr;
    logic        req0_ready, req1_ready;
    logic        lk_valid;
    logic [20:0] lk_tag;
    logic [2:0]  lk_set;
    logic [1:0]  lk_sblk;
    logic        lk_done, lk_hit;
    logic [1:0]  lk_way;
    logic        fill_req;
    logic [31:0] fill_addr;
    logic        fill_ack;
    logic [1:0]  fill_way;
    logic        lru_upd;
    logic [2:0]  lru_set;
    logic [1:0]  lru_way;
    logic        rsp_valid, rsp_id, rsp_hit;
    logic [1:0]  rsp_way;
    logic        busy;
`ifdef YACC_PERF_CNT_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    yacc_access_ctrl dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req0_valid (req0_valid),
        .req0_addr  (req0_addr),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_addr  (req1_addr),
        .req1_ready (req1_ready),
        .lk_valid   (lk_valid),
        .lk_tag     (lk_tag),
        .lk_set     (lk_set),
        .lk_sblk    (lk_sblk),
        .lk_done    (lk_done),
        .lk_hit     (lk_hit),
        .lk_way     (lk_way),
        .fill_req   (fill_req),
        .fill_addr  (fill_addr),
        .fill_ack   (fill_ack),
        .fill_way   (fill_way),
        .lru_upd    (lru_upd),
        .lru_set    (lru_set),
        .lru_way    (lru_way),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_hit    (rsp_hit),
        .rsp_way    (rsp_way),
        .busy       (busy)
`ifdef YACC_PERF_CNT_EN
        ,
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic       id;
        logic       hit;
        logic [1:0] way;
    } rsp_t;

    rsp_t q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; return 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait (bounded) for rsp_valid, then pop the scoreboard and compare.
    task automatic wait_rsp(input string tag);
        int   n;
        rsp_t e;
        n = 0;
        while (!rsp_valid && n < 30) begin
            tick();
            n++;
        end
        chk({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_sb_nonempty"}, 32'(q.size() > 0), 32'd1);
        if (rsp_valid && q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_rsp_id"},  32'(rsp_id),  32'(e.id));
            chk({tag, "_rsp_hit"}, 32'(rsp_hit), 32'(e.hit));
            chk({tag, "_rsp_way"}, 32'(rsp_way), 32'(e.way));
        end
    endtask

    // Full transaction from one requester; called in an IDLE cycle.
    task automatic do_req(input string tag, input logic id, input logic [31:0] a,
                          input logic h, input logic [1:0] w);
        int   n;
        logic rdy;
        if (id) begin req1_valid = 1'b1; req1_addr = a; end
        else    begin req0_valid = 1'b1; req0_addr = a; end
        #1;
        n   = 0;
        rdy = id ? req1_ready : req0_ready;
        while (!rdy && n < 30) begin
            tick();
            n++;
            rdy = id ? req1_ready : req0_ready;
        end
        chk({tag, "_grant"}, 32'(rdy), 32'd1);
        q.push_back('{id: id, hit: h, way: w});
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        lk_done = 1'b1;
        lk_hit  = h;
        lk_way  = h ? w : 2'd0;
        tick();
        lk_done = 1'b0;
        lk_hit  = 1'b0;
        if (!h) begin
            fill_ack = 1'b1;
            fill_way = w;
            tick();
            fill_ack = 1'b0;
        end
        wait_rsp(tag);
        tick();
    endtask

    initial begin
        rsp_t e;
        int   expid;
        req0_valid = 0; req1_valid = 0;
        req0_addr  = 0; req1_addr  = 0;
        lk_done = 0; lk_hit = 0; lk_way = 0;
        fill_ack = 0; fill_way = 0;
        reset_n = 1'b0;
        tick();
        tick();

        // ---------------- reset state ----------------
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_lk_valid",  32'(lk_valid),  32'd0);
        chk("rst_fill_req",  32'(fill_req),  32'd0);
        chk("rst_fill_addr", fill_addr,      32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_lru",       32'({lru_upd, lru_set, lru_way}), 32'd0);
        reset_n = 1'b1;
        tick();

        // ---------------- hit, exact latency ----------------
        req0_valid = 1'b1;
        req0_addr  = 32'h0000_0040;
        #1;
        chk("hit_c0_ready0", 32'(req0_ready), 32'd1);
        chk("hit_c0_ready1", 32'(req1_ready), 32'd0);
        q.push_back('{id: 1'b0, hit: 1'b1, way: 2'd2});
        tick();                                   // cycle 1
        req0_valid = 1'b0;
        chk("hit_c1_lk_valid", 32'(lk_valid), 32'd1);
        chk("hit_lk_tag",  32'(lk_tag),  32'd0);
        chk("hit_lk_set",  32'(lk_set),  32'd0);
        chk("hit_lk_sblk", 32'(lk_sblk), 32'd1);
        tick();                                   // cycle 2
        chk("hit_c2_lk_valid", 32'(lk_valid), 32'd0);
        lk_done = 1'b1; lk_hit = 1'b1; lk_way = 2'd2;
        tick();                                   // cycle 3
        lk_done = 1'b0; lk_hit = 1'b0; lk_way = 2'd0;
        chk("hit_c3_lru_upd", 32'(lru_upd), 32'd1);
        chk("hit_c3_lru_set", 32'(lru_set), 32'd0);
        chk("hit_c3_lru_way", 32'(lru_way), 32'd2);
        chk("hit_c3_rsp",     32'(rsp_valid), 32'd0);
        tick();                                   // cycle 4
        chk("hit_c4_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("hit_c4_ready",     32'(req0_ready | req1_ready), 32'd0);
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("hit_rsp_id",  32'(rsp_id),  32'(e.id));
            chk("hit_rsp_hit", 32'(rsp_hit), 32'(e.hit));
            chk("hit_rsp_way", 32'(rsp_way), 32'(e.way));
        end
        tick();                                   // cycle 5
        chk("hit_c5_busy", 32'(busy),      32'd0);
        chk("hit_c5_rsp",  32'(rsp_valid), 32'd0);

        // ---------------- miss with delayed fill ----------------
        req1_valid = 1'b1;
        req1_addr  = 32'h0000_1170;
        #1;
        chk("miss_ready1", 32'(req1_ready), 32'd1);
        q.push_back('{id: 1'b1, hit: 1'b0, way: 2'd3});
        tick();
        req1_valid = 1'b0;
        chk("miss_lk_valid", 32'(lk_valid), 32'd1);
        chk("miss_lk_tag",  32'(lk_tag),  32'd2);
        chk("miss_lk_set",  32'(lk_set),  32'd1);
        chk("miss_lk_sblk", 32'(lk_sblk), 32'd1);
        tick();
        lk_done = 1'b1; lk_hit = 1'b0;
        tick();                                   // cycle 3: first FILL cycle
        lk_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("miss_fill_req_hold", 32'(fill_req), 32'd1);
            chk("miss_fill_addr",     fill_addr,     32'h0000_1140);
            chk("miss_no_lru",        32'(lru_upd),  32'd0);
            if (i < 4) tick();
        end
        fill_ack = 1'b1; fill_way = 2'd3;
        tick();
        fill_ack = 1'b0; fill_way = 2'd0;
        chk("miss_fill_drop", 32'(fill_req), 32'd0);
        chk("miss_lru_upd",   32'(lru_upd),  32'd1);
        chk("miss_lru_set",   32'(lru_set),  32'd1);
        chk("miss_lru_way",   32'(lru_way),  32'd3);
        wait_rsp("miss");
        tick();

        // ---------------- arbitration, both always valid ----------------
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        tick();
        req0_valid = 1'b1; req0_addr = 32'h0000_0100;
        req1_valid = 1'b1; req1_addr = 32'h0000_0200;
        for (int i = 0; i < 4; i++) begin
            expid = i % 2;
            #1;
            chk("arb_ready0", 32'(req0_ready), 32'(expid == 0));
            chk("arb_ready1", 32'(req1_ready), 32'(expid == 1));
            q.push_back('{id: expid[0], hit: 1'b1, way: 2'(i)});
            tick();                               // LOOKUP
            chk("arb_busy_ready", 32'(req0_ready | req1_ready), 32'd0);
            tick();                               // LK_WAIT
            lk_done = 1'b1; lk_hit = 1'b1; lk_way = 2'(i);
            tick();                               // UPDATE
            lk_done = 1'b0; lk_hit = 1'b0;
            wait_rsp("arb");
            tick();                               // IDLE
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // ---------------- reset while in FILL ----------------
        req0_valid = 1'b1; req0_addr = 32'h0000_2A80;
        tick();
        req0_valid = 1'b0;
        tick();
        lk_done = 1'b1; lk_hit = 1'b0;
        tick();
        lk_done = 1'b0;
        chk("rfill_in_fill", 32'(fill_req), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rfill_fill_req", 32'(fill_req), 32'd0);
        chk("rfill_busy",     32'(busy),     32'd0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rfill_no_rsp", 32'(rsp_valid), 32'd0);
        end
        do_req("post_rst", 1'b1, 32'h0000_0780, 1'b1, 2'd1);

        // ---------------- spurious lk_done / fill_ack in IDLE ----------------
        lk_done = 1'b1; lk_hit = 1'b1; fill_ack = 1'b1; fill_way = 2'd2;
        tick();
        lk_done = 1'b0; lk_hit = 1'b0; fill_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("spur_busy", 32'(busy), 32'd0);
            chk("spur_rsp",  32'(rsp_valid | lk_valid | fill_req | lru_upd), 32'd0);
            tick();
        end
        do_req("post_spur", 1'b0, 32'h0000_00C0, 1'b0, 2'd0);

`ifdef YACC_PERF_CNT_EN
        // ---------------- performance counters ----------------
        reset_n = 1'b0;
        #1;
        chk("perf_rst_hit",  32'(hit_cnt),  32'd0);
        chk("perf_rst_miss", 32'(miss_cnt), 32'd0);
        reset_n = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) do_req("perf_h", i[0], 32'h0000_0040, 1'b1, 2'(i));
        for (int i = 0; i < 2; i++) do_req("perf_m", i[0], 32'h0000_1000, 1'b0, 2'(i));
        chk("perf_hit_cnt",  32'(hit_cnt),  32'd3);
        chk("perf_miss_cnt", 32'(miss_cnt), 32'd2);
`endif

        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/yacc_access_ctrl.md
Name: yacc_access_ctrl

Overview:
- Front-end sequencer for the YACC compressed cache.
- Round-robin arbitration between two address requesters.
- Splits the accepted 32-bit address into tag/set/superblock-slot fields and drives one lookup into the tag/LRU arrays.
- On a miss, runs a fill handshake to the memory side, then issues the LRU update and a one-cycle response; one request in flight at a time.

Parameters:
- ADDR_W, 32, request address width
- OFF_W, 6, byte-offset bits, addr[5:0]
- SB_W, 2, superblock slot bits, addr[7:6]
- SET_W, 3, set index bits, addr[10:8]
- TAG_W, 21, tag bits, addr[31:11]; ADDR_W must equal TAG_W+SET_W+SB_W+OFF_W
- WAY_W, 2, way index width (4 ways)

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an address
- req0_addr  in  ADDR_W  requester 0 address
- req0_ready  out  1  requester 0 accepted this cycle
- req1_valid  in  1  requester 1 has an address
- req1_addr  in  ADDR_W  requester 1 address
- req1_ready  out  1  requester 1 accepted this cycle
- lk_valid  out  1  one-cycle lookup strobe
- lk_tag  out  TAG_W  lookup tag
- lk_set  out  SET_W  lookup set
- lk_sblk  out  SB_W  lookup superblock slot
- lk_done  in  1  lookup result valid
- lk_hit  in  1  hit flag, sampled only with lk_done
- lk_way  in  WAY_W  hit way, sampled only with lk_done
- fill_req  out  1  memory fill request, level
- fill_addr  out  ADDR_W  block-aligned fill address
- fill_ack  in  1  fill complete
- fill_way  in  WAY_W  victim way written by fill, sampled with fill_ack
- lru_upd  out  1  one-cycle LRU touch strobe
- lru_set  out  SET_W  set to touch
- lru_way  out  WAY_W  way to mark MRU
- rsp_valid  out  1  one-cycle completion strobe
- rsp_id  out  1  requester that owns the response
- rsp_hit  out  1  1 = hit, 0 = miss-then-fill
- rsp_way  out  WAY_W  way holding the data
- busy  out  1  high whenever state != IDLE

Behaviour:
- Clock is `clock`; reset is `reset_n`, asynchronous assert, active-low, synchronous deassert by the system.
- Reset values:
  - state IDLE; rr pointer 0, so req0 has priority first.
  - All outputs 0, including lk_*, fill_addr, lru_*, rsp_*.
- FSM states: IDLE, LOOKUP, LK_WAIT, FILL, UPDATE, RESP.
- IDLE:
  - Only one valid requester: grant it.
  - Both valid: grant the requester named by the rr pointer, then set the pointer to the other requester.
  - A single grant also sets the pointer to the other requester.
  - reqN_ready is combinational, high only in IDLE for the granted requester. The transfer happens on valid&&ready.
  - On transfer: latch the address and the requester id, go to LOOKUP.
  - Requesters hold valid and addr stable until ready.
- LOOKUP:
  - Drive lk_valid=1 for exactly one cycle.
  - lk_tag/lk_set/lk_sblk come from the latched address and stay stable until the next accept.
  - Go to LK_WAIT.
- LK_WAIT:
  - Wait on lk_done, with no timeout.
  - lk_done && lk_hit: latch lk_way, hit=1, go to UPDATE.
  - lk_done && !lk_hit: hit=0, go to FILL.
- FILL:
  - Assert fill_req from FILL entry and hold it until fill_ack is sampled high.
  - fill_addr = {tag,set,sblk,OFF_W'b0}.
  - fill_ack is accepted in the first FILL cycle if it is already high.
  - On fill_ack: latch fill_way, drop fill_req the next cycle, go to UPDATE.
- UPDATE:
  - lru_upd=1 for one cycle, with lru_set = latched set and lru_way = latched way.
  - Go to RESP.
- RESP:
  - rsp_valid=1 for one cycle, with rsp_id, rsp_hit and rsp_way.
  - Go to IDLE. No new accept is possible in this cycle.
- Latency, with accept = cycle 0:
  - lk_valid in cycle 1.
  - Hit with lk_done in cycle 2: lru_upd in cycle 3, rsp_valid in cycle 4, next accept earliest in cycle 5.
  - Miss: add the FILL cycles, fill_req first high in cycle 3.
- Ignored inputs: lk_done outside LK_WAIT, and fill_ack outside FILL.
- Reset mid-operation: returns to IDLE at once and drops fill_req, lk_valid and lru_upd. The in-flight request gets no response and its requester must re-issue.
- busy = (state != IDLE).

Optional Feature:
- Macro: YACC_PERF_CNT_EN.
- Defined: adds outputs hit_cnt[15:0] and miss_cnt[15:0].
  - Both reset to 0.
  - In the RESP cycle, increment hit_cnt if rsp_hit=1, otherwise miss_cnt.
  - Both saturate at 16'hFFFF.
- Not defined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
- Hit:
  - Stimulus: req0 addr 32'h0000_0040, lk_done+lk_hit in cycle 2, lk_way=2.
  - Required: lk_tag=0, lk_set=0, lk_sblk=1; lru_upd in cycle 3 with set 0, way 2; rsp_valid in cycle 4 with id 0, hit 1, way 2.
- Miss:
  - Stimulus: req1 addr 32'h0000_1170, lk_hit=0, fill_ack after 5 cycles with fill_way=3.
  - Required: lk_tag=2, lk_set=1, lk_sblk=1; fill_addr=32'h0000_1140, held until ack; lru_way=3; rsp hit=0, id=1, way=3.
- Arbitration:
  - Stimulus: req0 and req1 valid continuously after reset, all lookups hit.
  - Required: grants alternate 0,1,0,1; no requester is granted twice in a row.
- Reset mid-fill:
  - Stimulus: reset_n low while in FILL.
  - Required: fill_req=0 and busy=0 in the same cycle; no rsp_valid; the next request is processed normally.
- Spurious inputs:
  - Stimulus: lk_done and fill_ack pulsed while in IDLE.
  - Required: no state change, no rsp_valid.
- With YACC_PERF_CNT_EN:
  - Stimulus: 3 hits then 2 misses.
  - Required: hit_cnt=3, miss_cnt=2; a forced 16'hFFFF value stays at 16'hFFFF.
